// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (receiver and transmitter).
//   rx_state_t      : receiver FSM state encoding
//   UART_DATA_WD    : default number of data bits per frame
//   UART_OVERSAMPLE : default clock cycles per bit (even, >= 4)
//   par_calc()      : parity bit for a word, even (odd=0) or odd (odd=1)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int UART_DATA_WD    = 8;
  localparam int UART_OVERSAMPLE = 8;

  // Widest word par_calc accepts; narrower words are zero-extended by the
  // caller, which leaves the XOR reduction unchanged.
  localparam int PAR_MAX_WD = 32;

  function automatic logic par_calc(input logic [PAR_MAX_WD-1:0] data,
                                    input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Oversampling bit-timing engine for uart_rx. Runs edge_cnt across each bit
// period and produces one decided bit per period.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN
//   defined     : bit = 2-of-3 majority of samples at OS/2-1, OS/2, OS/2+1
//   not defined : bit = single sample at OS/2
// Ports:
//   clk         in   receiver clock
//   rst_n       in   asynchronous active-low reset
//   rx_in       in   serial line (already synchronous to clk)
//   active      in   1 = keep counting next cycle, 0 = hold edge_cnt at 0
//   edge_cnt    out  position inside the current bit period
//   sampled_bit out  decided bit value, valid while sample_done is high
//   sample_done out  high in the cycle the bit decision is made
// -----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_in,
  input  logic                          active,
  output logic [$clog2(OVERSAMPLE)-1:0] edge_cnt,
  output logic                          sampled_bit,
  output logic                          sample_done
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] MID_EDGE  = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] LATE_EDGE = CNT_W'(OVERSAMPLE / 2 + 1);

  logic s_mid;

  // edge_cnt is held at 0 whenever the receiver will be idle next cycle, so a
  // start edge always lines up with edge_cnt = 0 on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (!active || edge_cnt == LAST_EDGE) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_mid <= 1'b0;
    end else if (edge_cnt == MID_EDGE) begin
      s_mid <= rx_in;
    end
  end

  // The decision is taken while the third (late) sample is still on the line,
  // so it uses rx_in directly rather than a stored copy.
  assign sample_done = (edge_cnt == LATE_EDGE);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CNT_W-1:0] EARLY_EDGE = CNT_W'(OVERSAMPLE / 2 - 1);

  logic s_early;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_early <= 1'b0;
    end else if (edge_cnt == EARLY_EDGE) begin
      s_early <= rx_in;
    end
  end

  assign sampled_bit = (s_early & s_mid) | (s_early & rx_in) | (s_mid & rx_in);
`else
  assign sampled_bit = s_mid;
`endif

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: 1 start bit, DATA_WD data bits LSB first,
// optional parity bit, 1 stop bit. Presents each good word with a one-cycle
// Data_Valid strobe; parity and stop errors pulse Par_Err / Stp_Err instead.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN (majority-vote sampling,
// handled in uart_rx_sampler).
// Ports:
//   CLK           in   receiver clock, OVERSAMPLE x bit rate
//   RST           in   asynchronous active-low reset
//   RX_IN         in   serial line, idle high, synchronous to CLK
//   parity_enable in   1 = frame carries a parity bit (latched at start edge)
//   parity_type   in   0 = even, 1 = odd (latched at start edge)
//   P_DATA        out  last correctly received word
//   Data_Valid    out  one-cycle pulse, P_DATA updated
//   Par_Err       out  one-cycle pulse, parity mismatch
//   Stp_Err       out  one-cycle pulse, stop bit sampled 0
//   busy          out  high while a frame is being received
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WD    = UART_DATA_WD,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               parity_enable,
  input  logic               parity_type,
  output logic [DATA_WD-1:0] P_DATA,
  output logic               Data_Valid,
  output logic               Par_Err,
  output logic               Stp_Err,
  output logic               busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_WD);
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WD - 1);

  rx_state_t          state;
  rx_state_t          next_state;
  logic [CNT_W-1:0]   edge_cnt;
  logic               sampled_bit;
  logic               sample_done;
  logic               bit_end;
  logic               start_det;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DATA_WD-1:0] data_reg;
  logic               par_en_q;
  logic               par_type_q;
  logic               par_err_q;
  logic               valid_set;
  logic               perr_set;
  logic               serr_set;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk         (CLK),
    .rst_n       (RST),
    .rx_in       (RX_IN),
    .active      (next_state != IDLE),
    .edge_cnt    (edge_cnt),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done)
  );

  assign bit_end   = (edge_cnt == LAST_EDGE);
  assign start_det = (state == IDLE) && !RX_IN;
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // STOP leaves at the decision point rather than the bit boundary, so the
  // receiver is already idle during the tail of the stop bit and can catch a
  // back-to-back start edge.
  always_comb begin
    next_state = state;
    valid_set  = 1'b0;
    perr_set   = 1'b0;
    serr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) next_state = START;
      end
      START: begin
        if (sample_done && sampled_bit) next_state = IDLE;
        else if (bit_end)               next_state = DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt == LAST_BIT) next_state = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) next_state = STOP;
      end
      STOP: begin
        if (sample_done) begin
          next_state = IDLE;
          valid_set  = sampled_bit && !par_err_q;
          serr_set   = !sampled_bit;
          perr_set   = par_err_q;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: frame configuration latched at the start edge, data bits written
  // by position, parity checked at its decision point, results registered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
      bit_cnt    <= '0;
      data_reg   <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      Data_Valid <= valid_set;
      Par_Err    <= perr_set;
      Stp_Err    <= serr_set;
      if (valid_set) begin
        P_DATA <= data_reg;
      end
      if (start_det) begin
        par_en_q   <= parity_enable;
        par_type_q <= parity_type;
        par_err_q  <= 1'b0;
        bit_cnt    <= '0;
      end
      if (state == DATA && sample_done) begin
        data_reg[bit_cnt] <= sampled_bit;
      end
      if (state == DATA && bit_end) begin
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end
      if (state == PARITY && sample_done &&
          sampled_bit != par_calc(PAR_MAX_WD'(data_reg), par_type_q)) begin
        par_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed testbench for uart_rx at DATA_WD=8, OVERSAMPLE=8. Frames are driven
// bit by bit; a negedge monitor logs result pulses relative to the frame's
// cycle 0 (first cycle RX_IN is low).
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       parity_enable;
  logic       parity_type;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;
  logic       busy;

  int checkCount = 0;
  int errorCount = 0;

  int cycle = 0;
  int frameStart = 0;
  int dvCnt, perrCnt, serrCnt;
  int dvCyc, perrCyc, serrCyc, busyFall;
  logic prevBusy = 1'b0;
  logic [7:0] dvLog[$];

  uart_rx #(
    .DATA_WD    (8),
    .OVERSAMPLE (OS)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_IN         (RX_IN),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .P_DATA        (P_DATA),
    .Data_Valid    (Data_Valid),
    .Par_Err       (Par_Err),
    .Stp_Err       (Stp_Err),
    .busy          (busy)
  );

  // Free-running clock and a cycle counter that stimulus uses as its timebase.
  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle++;

  // Monitor: samples outputs on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (Data_Valid) begin
      dvCnt++;
      dvCyc = cycle - frameStart;
      dvLog.push_back(P_DATA);
    end
    if (Par_Err) begin
      perrCnt++;
      perrCyc = cycle - frameStart;
    end
    if (Stp_Err) begin
      serrCnt++;
      serrCyc = cycle - frameStart;
    end
    if (prevBusy && !busy) busyFall = cycle - frameStart;
    prevBusy = busy;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMonitor();
    dvCnt = 0; perrCnt = 0; serrCnt = 0;
    dvCyc = -1; perrCyc = -1; serrCyc = -1; busyFall = -1;
    dvLog.delete();
  endtask

  task automatic idleCycles(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives one frame starting right now (called #1 after a rising edge).
  // glitchBit selects a frame bit (0 = start) whose second cycle is inverted.
  task automatic applyStimulus(input logic [7:0] data, input bit withPar,
                               input bit parBit, input bit stopBit,
                               input int glitchBit);
    logic [10:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    if (withPar) begin
      bits[9]  = parBit;
      bits[10] = stopBit;
      n = 11;
    end else begin
      bits[9] = stopBit;
      n = 10;
    end
    frameStart = cycle;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < OS; c++) begin
        RX_IN = (k == glitchBit && c == 1) ? ~bits[k] : bits[k];
        @(posedge CLK);
        #1;
      end
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    RST = 1'b0;
    RX_IN = 1'b1;
    parity_enable = 1'b0;
    parity_type = 1'b0;
    clearMonitor();
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_pdata", P_DATA, 8'h00);
    checkOutput("rst_dv", Data_Valid, 0);
    checkOutput("rst_perr", Par_Err, 0);
    checkOutput("rst_serr", Stp_Err, 0);
    checkOutput("rst_busy", busy, 0);
    RST = 1'b1;
    idleCycles(3);

    // No parity, 0xA3: result at (10-1)*8 + 8/2 + 2 = 78.
    $display("[TB] frame 0xA3, parity off");
    clearMonitor();
    applyStimulus(8'hA3, 0, 0, 1, -1);
    idleCycles(12);
    checkOutput("a3_pdata", P_DATA, 8'hA3);
    checkOutput("a3_dv_cnt", dvCnt, 1);
    checkOutput("a3_dv_cyc", dvCyc, 78);
    checkOutput("a3_perr_cnt", perrCnt, 0);
    checkOutput("a3_serr_cnt", serrCnt, 0);

    // Even parity, 0xB4 has four ones -> parity bit 0. Result at 10*8+6 = 86.
    $display("[TB] frame 0xB4, even parity");
    parity_enable = 1'b1;
    parity_type = 1'b0;
    clearMonitor();
    applyStimulus(8'hB4, 1, 0, 1, -1);
    idleCycles(12);
    checkOutput("b4_pdata", P_DATA, 8'hB4);
    checkOutput("b4_dv_cnt", dvCnt, 1);
    checkOutput("b4_dv_cyc", dvCyc, 86);
    checkOutput("b4_perr_cnt", perrCnt, 0);

    // Odd parity, 0xD2 has four ones so the odd parity bit is 1; drive 0.
    $display("[TB] frame 0xD2, odd parity, wrong parity bit");
    parity_type = 1'b1;
    clearMonitor();
    applyStimulus(8'hD2, 1, 0, 1, -1);
    idleCycles(12);
    checkOutput("d2_perr_cnt", perrCnt, 1);
    checkOutput("d2_perr_cyc", perrCyc, 86);
    checkOutput("d2_dv_cnt", dvCnt, 0);
    checkOutput("d2_pdata_held", P_DATA, 8'hB4);
    checkOutput("d2_serr_cnt", serrCnt, 0);

    // Parity off, 0x5A with a 0 stop bit.
    $display("[TB] frame 0x5A, bad stop bit");
    parity_enable = 1'b0;
    parity_type = 1'b0;
    clearMonitor();
    applyStimulus(8'h5A, 0, 0, 0, -1);
    checkOutput("5a_serr_cnt", serrCnt, 1);
    checkOutput("5a_serr_cyc", serrCyc, 78);
    checkOutput("5a_dv_cnt", dvCnt, 0);
    checkOutput("5a_pdata_held", P_DATA, 8'hB4);
    idleCycles(12);

    // Short low pulse: start decided as 1 at edge 5, idle from the next cycle.
    $display("[TB] false start");
    clearMonitor();
    frameStart = cycle;
    RX_IN = 1'b0;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    idleCycles(12);
    checkOutput("glitch_busy_fall", busyFall, 6);
    checkOutput("glitch_dv_cnt", dvCnt, 0);
    checkOutput("glitch_err_cnt", perrCnt + serrCnt, 0);

    // Back-to-back frames with no idle gap.
    $display("[TB] back-to-back 0x01, 0xFF");
    clearMonitor();
    applyStimulus(8'h01, 0, 0, 1, -1);
    applyStimulus(8'hFF, 0, 0, 1, -1);
    idleCycles(12);
    checkOutput("b2b_dv_cnt", dvCnt, 2);
    checkOutput("b2b_word0", (dvLog.size() > 0) ? dvLog[0] : 8'hEE, 8'h01);
    checkOutput("b2b_word1", (dvLog.size() > 1) ? dvLog[1] : 8'hEE, 8'hFF);
    checkOutput("b2b_dv_cyc", dvCyc, 78);

    // Reset asserted in cycle 40 of a frame.
    $display("[TB] reset mid-frame");
    clearMonitor();
    fork
      applyStimulus(8'h96, 0, 0, 1, -1);
      begin
        repeat (40) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_pdata", P_DATA, 8'h00);
        checkOutput("abort_dv", Data_Valid, 0);
      end
    join
    checkOutput("abort_dv_cnt", dvCnt, 0);
    RST = 1'b1;
    idleCycles(3);
    clearMonitor();
    applyStimulus(8'h69, 0, 0, 1, -1);
    idleCycles(12);
    checkOutput("post_rst_pdata", P_DATA, 8'h69);
    checkOutput("post_rst_dv_cnt", dvCnt, 1);

    // One-cycle glitch at edge 1 of data bit 2 (frame bit 3); value 1 is kept.
    $display("[TB] off-centre glitch on 0x3C");
    clearMonitor();
    applyStimulus(8'h3C, 0, 0, 1, 3);
    idleCycles(12);
    checkOutput("offc_pdata", P_DATA, 8'h3C);
    checkOutput("offc_dv_cnt", dvCnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
